bird_datapath: RTL
==================

BIRD_DATAPATH -- requirements
Module: bird_datapath

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: STATE  input  4  bird control state code (encodings in REQ-012).
REQ-004 SHALL have port: x  output  8  pixel column to VGA adapter, 0..159.
REQ-005 SHALL have port: y  output  7  pixel row to VGA adapter, 0..119.
REQ-006 SHALL have port: colour  output  3  pixel colour.
REQ-007 SHALL have port: plot  output  1  write-enable for (x,y,colour).
REQ-008 SHALL have port: doneDrawing  output  1  current clear/draw scan complete.
REQ-009 SHALL have port: flying  output  1  bird falling (shot) or escaping (out of ammo).
REQ-010 SHALL have parameters, one per line: SPAWN_X, 76, reset/respawn column; SPAWN_Y, 100, reset/respawn row; FLY_STEP, 2, pixels per fall/escape step.

Function
REQ-011 Bird position bx (8 bit) and by (7 bit) SHALL be the top-left of an 8x8 sprite.
REQ-012 STATE codes SHALL be: PREHOLD 0100, HOLD 0000, CLEAR 0001, UP_RIGHT 0011, UP_LEFT 0010, DOWN_RIGHT 0110, DOWN_LEFT 0111, DRAW 0101, SHOT 1000, ESCAPE 1001; undefined codes behave as HOLD.
REQ-013 A registered prev_state SHALL detect entry; the first cycle with STATE != prev_state is scan index 0.
REQ-014 In CLEAR or DRAW, scan indices 0..63 SHALL each take one cycle with plot=1, x=bx+idx[2:0], y=by+idx[5:3], row-major.
REQ-015 doneDrawing SHALL be 0 during indices 0..63, 1 from cycle 64 after entry while STATE unchanged, and 0 in all other states; plot=0 once done.
REQ-016 CLEAR colour SHALL be 3'b011 (sky); DRAW colour 3'b110 normally, 3'b100 while falling.
REQ-017 Each move state SHALL update position once at its single-cycle end: UP ±x+1/y-1, DOWN y+1, RIGHT x+1, LEFT x-1, per state name.
REQ-018 Move updates SHALL saturate: bx in 0..152, by in 0..112; no wrap-around; plot=0 in move states.
REQ-019 SHOT SHALL set flying_reg=1 and falling=1; ESCAPE SHALL set flying_reg=1 and falling=0; both have plot=0.
REQ-020 flying SHALL equal flying_reg OR (STATE==SHOT) OR (STATE==ESCAPE), combinationally, so the controller sees it in the SHOT/ESCAPE cycle.
REQ-021 When STATE==CLEAR, doneDrawing=1 and flying_reg=1, the next edge SHALL move by+FLY_STEP (falling) or by-FLY_STEP (escaping).
REQ-022 If that step would pass by>=112 (falling) or by<FLY_STEP (escaping), the SAME edge SHALL clear flying_reg and falling and load bx=SPAWN_X, by=SPAWN_Y.
REQ-023 SHOT arriving while already flying SHALL re-force falling=1 (shot overrides escape).
REQ-024 In PREHOLD, HOLD and undefined states outputs SHALL be plot=0, doneDrawing=0, position held.

Reset
REQ-025 On reset_n low, immediately: bx=SPAWN_X, by=SPAWN_Y, flying_reg=0, falling=0, scan counter=0, prev_state=PREHOLD, plot=0, doneDrawing=0, x=0, y=0, colour=0.
REQ-026 Reset mid-scan SHALL abort the scan; after release, the scan restarts at index 0 on the next CLEAR/DRAW entry.

Configuration
REQ-027 Macro BIRD_SPRITE_MASK_EN defined: DRAW SHALL look up an internal 64-bit 8x8 mask ROM; pixels with mask bit 0 get plot=0 (transparent), timing unchanged.
REQ-028 Macro undefined: DRAW SHALL plot all 64 pixels as a solid square; CLEAR is unaffected in both builds.

Verification
REQ-029 Reset, STATE=CLEAR -> 64 cycles plot=1, first (76,100) last (83,107), colour 3'b011, doneDrawing=1 at cycle 64.
REQ-030 bx=152, by=0, STATE=UP_RIGHT one cycle -> bx=152, by=0 (saturated); next DRAW scans from (152,0).
REQ-031 STATE=SHOT one cycle -> flying=1 in that cycle; subsequent CLEAR done -> by+2 per cycle, DRAW colour 3'b100.
REQ-032 Falling with by=110, CLEAR done -> flying=0 and bx=76, by=100 on the next cycle.
REQ-033 STATE=DRAW, reset_n low at index 30 -> plot=0 immediately; release, re-enter DRAW -> scan restarts at index 0.
REQ-034 With BIRD_SPRITE_MASK_EN, DRAW -> plot count equals mask popcount, doneDrawing still at cycle 64.

Source files
------------

// File: rtl/bird_datapath.sv
// rtl/bird_datapath.sv - bird sprite position, scan and flight datapath for the VGA adapter
//
// Optional feature: define BIRD_SPRITE_MASK_EN to draw the bird through an 8x8 mask ROM.
// Without it, DRAW paints a solid 8x8 square.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   STATE[3:0]   control state code from the bird controller
//   x[7:0]       pixel column, y[6:0] pixel row, colour[2:0] pixel colour
//   plot         write-enable for (x,y,colour)
//   doneDrawing  current CLEAR/DRAW scan has covered all 64 pixels
//   flying       bird is falling (shot) or escaping
module bird_datapath #(
    parameter logic [7:0] SPAWN_X  = 8'd76,
    parameter logic [6:0] SPAWN_Y  = 7'd100,
    parameter logic [6:0] FLY_STEP = 7'd2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] STATE,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       doneDrawing,
    output logic       flying
);

    localparam logic [3:0] S_PREHOLD    = 4'b0100;
    localparam logic [3:0] S_CLEAR      = 4'b0001;
    localparam logic [3:0] S_UP_RIGHT   = 4'b0011;
    localparam logic [3:0] S_UP_LEFT    = 4'b0010;
    localparam logic [3:0] S_DOWN_RIGHT = 4'b0110;
    localparam logic [3:0] S_DOWN_LEFT  = 4'b0111;
    localparam logic [3:0] S_DRAW       = 4'b0101;
    localparam logic [3:0] S_SHOT       = 4'b1000;
    localparam logic [3:0] S_ESCAPE     = 4'b1001;

    localparam logic [7:0] X_MAX = 8'd152;
    localparam logic [6:0] Y_MAX = 7'd112;

`ifdef BIRD_SPRITE_MASK_EN
    // Bit index = row*8 + column; row 0 is the sprite's top line.
    localparam logic [63:0] SPRITE_MASK = 64'h1824_7EFF_FF7E_3C18;
`endif

    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;
    logic       flying_q, flying_d;
    logic       falling_q, falling_d;
    logic [6:0] cnt_q, cnt_d;
    logic [3:0] prev_q;

    logic       entry;
    logic [6:0] idx;
    logic       scan_state;
    logic       done_int;
    logic [7:0] fall_sum;
    logic       plot_c;
    logic [7:0] x_c;
    logic [6:0] y_c;
    logic [2:0] colour_c;

    always_comb begin
        entry      = (STATE != prev_q);
        // The entry cycle itself is index 0, so the counter value is ignored there.
        idx        = entry ? 7'd0 : cnt_q;
        scan_state = (STATE == S_CLEAR) || (STATE == S_DRAW);
        done_int   = scan_state && idx[6];
        cnt_d      = idx[6] ? idx : idx + 7'd1;
        fall_sum   = {1'b0, by_q} + {1'b0, FLY_STEP};
    end

    always_comb begin
        bx_d      = bx_q;
        by_d      = by_q;
        flying_d  = flying_q;
        falling_d = falling_q;
        case (STATE)
            S_UP_RIGHT, S_UP_LEFT, S_DOWN_RIGHT, S_DOWN_LEFT: begin
                // Move once per entry even if the controller lingers in the state.
                if (entry) begin
                    if (STATE[0]) begin
                        if (STATE == S_UP_RIGHT)
                            bx_d = (bx_q >= X_MAX) ? X_MAX : bx_q + 8'd1;
                        else
                            bx_d = (bx_q == 8'd0) ? 8'd0 : bx_q - 8'd1;
                    end else begin
                        if (STATE == S_UP_LEFT)
                            bx_d = (bx_q == 8'd0) ? 8'd0 : bx_q - 8'd1;
                        else
                            bx_d = (bx_q >= X_MAX) ? X_MAX : bx_q + 8'd1;
                    end
                    if (STATE[2])
                        by_d = (by_q >= Y_MAX) ? Y_MAX : by_q + 7'd1;
                    else
                        by_d = (by_q == 7'd0) ? 7'd0 : by_q - 7'd1;
                end
            end
            S_SHOT: begin
                flying_d  = 1'b1;
                falling_d = 1'b1;
            end
            S_ESCAPE: begin
                flying_d  = 1'b1;
                falling_d = 1'b0;
            end
            S_CLEAR: begin
                // Flight advances one step per cycle once the old sprite is erased.
                if (done_int && flying_q) begin
                    if ((falling_q && fall_sum >= {1'b0, Y_MAX}) ||
                        (!falling_q && by_q < FLY_STEP)) begin
                        flying_d  = 1'b0;
                        falling_d = 1'b0;
                        bx_d      = SPAWN_X;
                        by_d      = SPAWN_Y;
                    end else if (falling_q) begin
                        by_d = fall_sum[6:0];
                    end else begin
                        by_d = by_q - FLY_STEP;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bx_q      <= SPAWN_X;
            by_q      <= SPAWN_Y;
            flying_q  <= 1'b0;
            falling_q <= 1'b0;
            cnt_q     <= 7'd0;
            prev_q    <= S_PREHOLD;
        end else begin
            bx_q      <= bx_d;
            by_q      <= by_d;
            flying_q  <= flying_d;
            falling_q <= falling_d;
            cnt_q     <= cnt_d;
            prev_q    <= STATE;
        end
    end

    always_comb begin
        plot_c   = scan_state && !idx[6];
`ifdef BIRD_SPRITE_MASK_EN
        if (STATE == S_DRAW)
            plot_c = plot_c && SPRITE_MASK[idx[5:0]];
`endif
        x_c      = scan_state ? bx_q + {5'd0, idx[2:0]} : 8'd0;
        y_c      = scan_state ? by_q + {4'd0, idx[5:3]} : 7'd0;
        colour_c = 3'b000;
        if (STATE == S_CLEAR)
            colour_c = 3'b011;
        else if (STATE == S_DRAW)
            colour_c = falling_q ? 3'b100 : 3'b110;
    end

    // Outputs are combinational, so reset must also force them low directly.
    assign plot        = reset_n && plot_c;
    assign doneDrawing = reset_n && done_int;
    assign x           = reset_n ? x_c : 8'd0;
    assign y           = reset_n ? y_c : 7'd0;
    assign colour      = reset_n ? colour_c : 3'b000;
    assign flying      = flying_q || (STATE == S_SHOT) || (STATE == S_ESCAPE);

endmodule
